// File: rtl/lagarto_exe_wb_pkg.sv
// lagarto_exe_wb_pkg: default widths, EXE->WB entry layout and write-enable sanitising helpers
package lagarto_exe_wb_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 40;
  localparam int INST_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int DEPTH_DEF  = 2;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
    logic                  we;
    logic [DATA_W_DEF-1:0] data;
    logic [REG_AW_DEF-1:0] waddr;
    logic                  csr_en;
    logic [DATA_W_DEF-1:0] csr_data;
    logic                  xcpt;
    logic [DATA_W_DEF-1:0] cause;
    logic [ADDR_W_DEF-1:0] mem_addr;
  } exe_wb_entry_t;
  // writes to x0 and from excepting instructions never reach the register file
  function automatic logic sanitise_we(input logic we, input logic xcpt, input logic waddr_nz);
    return we & ~xcpt & waddr_nz;
  endfunction
  function automatic logic sanitise_csr_en(input logic csr_en, input logic xcpt);
    return csr_en & ~xcpt;
  endfunction
endpackage

// File: rtl/exe_wb_queue_ctrl.sv
// exe_wb_queue_ctrl: circular-buffer pointers, occupancy count and push/pop/flush handshake
module exe_wb_queue_ctrl #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          exe_valid,
  input  logic          wb_ready,
  output logic          exe_ready,
  output logic          wb_valid,
  output logic          push,
  output logic          pop,
  output logic [PW-1:0] wptr,
  output logic [PW-1:0] rptr,
  output logic [CW-1:0] count
);
  assign exe_ready = count < CW'(DEPTH);
  assign wb_valid  = count != '0;
  assign push      = exe_valid & exe_ready & ~flush;
  assign pop       = wb_valid & wb_ready & ~flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(push);
      rptr  <= rptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/exe_wb_skid_latch.sv
// exe_wb_skid_latch: DEPTH-entry EXE->WB valid/ready queue; LAGARTO_EXE_WB_PERF_EN adds WB_STALL_CNT
module exe_wb_skid_latch
  import lagarto_exe_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              EXE_VALID,
  output logic              EXE_READY,
  input  logic [ADDR_W-1:0] EXE_PC,
  input  logic [INST_W-1:0] EXE_INST,
  input  logic              EXE_WE,
  input  logic [DATA_W-1:0] EXE_DATA,
  input  logic [REG_AW-1:0] EXE_WADDR,
  input  logic              EXE_CSR_ENABLE,
  input  logic              EXE_XCPT,
  input  logic [DATA_W-1:0] EXE_XCPT_CAUSE,
  input  logic [ADDR_W-1:0] EXE_MEM_ADDR,
  output logic              WB_VALID,
  input  logic              WB_READY,
  output logic [ADDR_W-1:0] WB_PC,
  output logic [INST_W-1:0] WB_INST,
  output logic              WB_WE,
  output logic [DATA_W-1:0] WB_DATA,
  output logic [REG_AW-1:0] WB_WADDR,
  output logic              WB_CSR_ENABLE,
  output logic [DATA_W-1:0] WB_CSR_DATA,
  output logic              WB_XCPT,
  output logic [DATA_W-1:0] WB_XCPT_CAUSE,
  output logic [ADDR_W-1:0] WB_MEM_ADDR,
  output logic [CW-1:0]     COUNT
`ifdef LAGARTO_EXE_WB_PERF_EN
  ,
  output logic [31:0]       WB_STALL_CNT
`endif
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              we;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] waddr;
    logic              csr_en;
    logic [DATA_W-1:0] csr_data;
    logic              xcpt;
    logic [DATA_W-1:0] cause;
    logic [ADDR_W-1:0] mem_addr;
  } entry_t;
  entry_t          mem [DEPTH];
  entry_t          din;
  entry_t          head;
  logic            push;
  logic            pop;
  logic            we;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  exe_wb_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk(CLK),
    .rst_n(RST),
    .flush(FLUSH),
    .exe_valid(EXE_VALID),
    .wb_ready(WB_READY),
    .exe_ready(EXE_READY),
    .wb_valid(WB_VALID),
    .push(push),
    .pop(pop),
    .wptr(wptr),
    .rptr(rptr),
    .count(COUNT)
  );
  assign we = sanitise_we(EXE_WE, EXE_XCPT, |EXE_WADDR);
  always_comb begin
    din.pc       = EXE_PC;
    din.inst     = EXE_INST;
    din.we       = we;
    din.data     = we ? EXE_DATA : '0;
    din.waddr    = we ? EXE_WADDR : '0;
    din.csr_en   = sanitise_csr_en(EXE_CSR_ENABLE, EXE_XCPT);
    din.csr_data = EXE_DATA;
    din.xcpt     = EXE_XCPT;
    din.cause    = EXE_XCPT_CAUSE;
    din.mem_addr = EXE_MEM_ADDR;
  end
  always_ff @(posedge CLK)
    if (push) mem[wptr] <= din;
  // payload reads as zero while the queue is empty
  assign head = WB_VALID ? mem[rptr] : '0;
  assign {WB_PC, WB_INST, WB_WE, WB_DATA, WB_WADDR, WB_CSR_ENABLE, WB_CSR_DATA,
          WB_XCPT, WB_XCPT_CAUSE, WB_MEM_ADDR} = head;
`ifdef LAGARTO_EXE_WB_PERF_EN
  always_ff @(posedge CLK or negedge RST)
    if (!RST) WB_STALL_CNT <= '0;
    else if (WB_VALID & ~WB_READY & ~FLUSH & ~&WB_STALL_CNT) WB_STALL_CNT <= WB_STALL_CNT + 32'd1;
`endif
  logic unused;
  assign unused = pop;
endmodule

// File: tb/tb_exe_wb_skid_latch.sv
// tb_exe_wb_skid_latch: randomized + directed scoreboard bench for exe_wb_skid_latch
module tb_exe_wb_skid_latch;
  localparam int DATA_W = 64, ADDR_W = 40, INST_W = 32, REG_AW = 5, DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  logic              CLK = 0, RST = 0, FLUSH = 0, EXE_VALID = 0, WB_READY = 0;
  logic [ADDR_W-1:0] EXE_PC = 0, EXE_MEM_ADDR = 0;
  logic [INST_W-1:0] EXE_INST = 0;
  logic              EXE_WE = 0, EXE_CSR_ENABLE = 0, EXE_XCPT = 0;
  logic [DATA_W-1:0] EXE_DATA = 0, EXE_XCPT_CAUSE = 0;
  logic [REG_AW-1:0] EXE_WADDR = 0;
  logic              EXE_READY, WB_VALID, WB_WE, WB_CSR_ENABLE, WB_XCPT;
  logic [ADDR_W-1:0] WB_PC, WB_MEM_ADDR;
  logic [INST_W-1:0] WB_INST;
  logic [DATA_W-1:0] WB_DATA, WB_CSR_DATA, WB_XCPT_CAUSE;
  logic [REG_AW-1:0] WB_WADDR;
  logic [CW-1:0]     COUNT;
`ifdef LAGARTO_EXE_WB_PERF_EN
  logic [31:0]       WB_STALL_CNT;
`endif
  exe_wb_skid_latch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INST_W(INST_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .EXE_VALID(EXE_VALID), .EXE_READY(EXE_READY),
    .EXE_PC(EXE_PC), .EXE_INST(EXE_INST), .EXE_WE(EXE_WE), .EXE_DATA(EXE_DATA), .EXE_WADDR(EXE_WADDR),
    .EXE_CSR_ENABLE(EXE_CSR_ENABLE), .EXE_XCPT(EXE_XCPT), .EXE_XCPT_CAUSE(EXE_XCPT_CAUSE),
    .EXE_MEM_ADDR(EXE_MEM_ADDR), .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_PC(WB_PC),
    .WB_INST(WB_INST), .WB_WE(WB_WE), .WB_DATA(WB_DATA), .WB_WADDR(WB_WADDR),
    .WB_CSR_ENABLE(WB_CSR_ENABLE), .WB_CSR_DATA(WB_CSR_DATA), .WB_XCPT(WB_XCPT),
    .WB_XCPT_CAUSE(WB_XCPT_CAUSE), .WB_MEM_ADDR(WB_MEM_ADDR), .COUNT(COUNT)
`ifdef LAGARTO_EXE_WB_PERF_EN
    , .WB_STALL_CNT(WB_STALL_CNT)
`endif
  );
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              we;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] waddr;
    logic              csr_en;
    logic [DATA_W-1:0] csr_data;
    logic              xcpt;
    logic [DATA_W-1:0] cause;
    logic [ADDR_W-1:0] mem_addr;
  } ent_t;
  ent_t        q[$];
  ent_t        act, exph;
  int          tests = 0, fails = 0;
  bit          mon_en = 0, pu, po;
  logic [31:0] stall = 0;
  assign act = {WB_PC, WB_INST, WB_WE, WB_DATA, WB_WADDR, WB_CSR_ENABLE, WB_CSR_DATA,
                WB_XCPT, WB_XCPT_CAUSE, WB_MEM_ADDR};
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic ent_t expect_ent();
    ent_t e;
    bit w;
    w = EXE_WE && !EXE_XCPT && EXE_WADDR != 0;
    e.pc = EXE_PC;
    e.inst = EXE_INST;
    e.we = w;
    e.data = w ? EXE_DATA : '0;
    e.waddr = w ? EXE_WADDR : '0;
    e.csr_en = EXE_CSR_ENABLE && !EXE_XCPT;
    e.csr_data = EXE_DATA;
    e.xcpt = EXE_XCPT;
    e.cause = EXE_XCPT_CAUSE;
    e.mem_addr = EXE_MEM_ADDR;
    return e;
  endfunction
  // reference queue: scoreboard of entries still owed to writeback
  always @(posedge CLK or negedge RST)
    if (!RST) begin
      q.delete();
      stall = 0;
    end else if (FLUSH) q.delete();
    else begin
      pu = EXE_VALID && q.size() < DEPTH;
      po = q.size() != 0 && WB_READY;
      if (q.size() != 0 && !WB_READY && stall != 32'hFFFF_FFFF) stall = stall + 1;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(expect_ent());
    end
  always @(negedge CLK)
    if (mon_en) begin
      exph = q.size() != 0 ? q[0] : '0;
      chk("count", 64'(COUNT), 64'(q.size()));
      chk("wb_valid", 64'(WB_VALID), 64'(q.size() != 0));
      chk("exe_ready", 64'(EXE_READY), 64'(q.size() < DEPTH));
      tests++;
      if (act !== exph) begin
        fails++;
        $display("FAIL head actual=%h expected=%h at %0t", act, exph, $time);
      end
`ifdef LAGARTO_EXE_WB_PERF_EN
      chk("stall_cnt", 64'(WB_STALL_CNT), 64'(stall));
`endif
    end
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic rnd_in();
    EXE_PC = ADDR_W'({$urandom, $urandom});
    EXE_INST = $urandom;
    EXE_WE = 1'($urandom);
    EXE_DATA = {$urandom, $urandom};
    EXE_WADDR = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom);
    EXE_CSR_ENABLE = 1'($urandom);
    EXE_XCPT = ($urandom_range(0, 3) == 0);
    EXE_XCPT_CAUSE = {$urandom, $urandom};
    EXE_MEM_ADDR = ADDR_W'({$urandom, $urandom});
  endtask
  initial begin
    step();
    step();
    RST = 1;
    mon_en = 1;
    chk("rst_valid", 64'(WB_VALID), 0);
    chk("rst_ready", 64'(EXE_READY), 1);
    chk("rst_count", 64'(COUNT), 0);
    // single push, consumed immediately
    rnd_in();
    EXE_VALID = 1; EXE_PC = 40'h1000; EXE_WE = 1; EXE_WADDR = 5; EXE_DATA = 64'hAB; EXE_XCPT = 0;
    WB_READY = 1;
    step();
    EXE_VALID = 0;
    chk("t1_valid", 64'(WB_VALID), 1);
    chk("t1_data", WB_DATA, 64'hAB);
    chk("t1_waddr", 64'(WB_WADDR), 5);
    chk("t1_pc", 64'(WB_PC), 64'h1000);
    step();
    chk("t1_empty", 64'(WB_VALID), 0);
    chk("t1_zero_pc", 64'(WB_PC), 0);
    chk("t1_zero_data", WB_DATA, 0);
    // fill past capacity with writeback blocked
    WB_READY = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      rnd_in();
      EXE_VALID = 1; EXE_PC = ADDR_W'(32'h2000 + i);
      step();
    end
    EXE_VALID = 0;
    chk("fill_ready", 64'(EXE_READY), 0);
    chk("fill_count", 64'(COUNT), DEPTH);
    WB_READY = 1;
    for (int i = 1; i < DEPTH; i++) begin
      step();
      chk("drain_pc", 64'(WB_PC), 64'(32'h2000 + i));
      chk("drain_ready", 64'(EXE_READY), 1);
    end
    step();
    chk("drain_empty", 64'(WB_VALID), 0);
    // exception suppresses architectural writes
    WB_READY = 0;
    rnd_in();
    EXE_VALID = 1; EXE_XCPT = 1; EXE_WE = 1; EXE_CSR_ENABLE = 1; EXE_WADDR = 7;
    EXE_XCPT_CAUSE = 64'h5; EXE_DATA = 64'h1234_5678;
    step();
    chk("xcpt_we", 64'(WB_WE), 0);
    chk("xcpt_data", WB_DATA, 0);
    chk("xcpt_csr_en", 64'(WB_CSR_ENABLE), 0);
    chk("xcpt_flag", 64'(WB_XCPT), 1);
    chk("xcpt_cause", WB_XCPT_CAUSE, 64'h5);
    chk("xcpt_csr_data", WB_CSR_DATA, 64'h1234_5678);
    // flush with concurrent push
    rnd_in();
    step();
    chk("pre_flush_count", 64'(COUNT), 2);
    rnd_in();
    FLUSH = 1; EXE_PC = 40'h3000;
    step();
    FLUSH = 0; EXE_VALID = 0;
    chk("flush_count", 64'(COUNT), 0);
    chk("flush_valid", 64'(WB_VALID), 0);
    step();
    chk("flush_dropped", 64'(WB_VALID), 0);
    // streaming: pointers wrap while occupancy holds at one
    WB_READY = 1;
    for (int i = 0; i < 10; i++) begin
      rnd_in();
      EXE_VALID = 1; EXE_PC = ADDR_W'(32'h4000 + i);
      step();
      chk("stream_pc", 64'(WB_PC), 64'(32'h4000 + i));
      chk("stream_count", 64'(COUNT), 1);
    end
    EXE_VALID = 0;
    step();
`ifdef LAGARTO_EXE_WB_PERF_EN
    RST = 0;
    step();
    RST = 1;
    WB_READY = 0;
    rnd_in();
    EXE_VALID = 1;
    step();
    EXE_VALID = 0;
    repeat (7) step();
    chk("stall_7", 64'(WB_STALL_CNT), 7);
    #2 RST = 0;
    #1 chk("stall_rst", 64'(WB_STALL_CNT), 0);
    step();
    RST = 1;
`endif
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rnd_in();
      EXE_VALID = 1'($urandom);
      WB_READY = ($urandom_range(0, 2) != 0);
      FLUSH = ($urandom_range(0, 15) == 0);
      step();
    end
    FLUSH = 0; EXE_VALID = 1; WB_READY = 0;
    repeat (3) step();
    // asynchronous reset mid-operation takes effect immediately
    #2 RST = 0;
    #1;
    chk("arst_count", 64'(COUNT), 0);
    chk("arst_valid", 64'(WB_VALID), 0);
    chk("arst_ready", 64'(EXE_READY), 1);
    chk("arst_pc", 64'(WB_PC), 0);
    chk("arst_data", WB_DATA, 0);
    step();
    RST = 1;
    EXE_VALID = 0;
    step();
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
